// File: rtl/ff_div_skid.sv
// ff_div_skid: elastic register slice for the divider datapath.
// Carries LANES x WIDTH operands plus a TAG_W iteration tag per beat, using a
// valid/ready handshake and a two-entry (main + skid) buffer. Downstream
// back-pressure stalls the pipe without losing beats.
//
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   ld                synchronous flush of all held beats
//   s_valid/s_ready   upstream handshake (s_ready registered)
//   s_data/s_tag      upstream payload and tag
//   m_valid/m_ready   downstream handshake (m_valid registered)
//   m_data/m_tag      downstream payload and tag (registered)
//   occupancy         held beats, 0..2
//   stall_cnt         saturating count of m_valid && !m_ready cycles
module ff_div_skid #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   ld,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic [TAG_W-1:0]       s_tag,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [LANES*WIDTH-1:0] m_data,
  output logic [TAG_W-1:0]       m_tag,
  output logic [1:0]             occupancy,
  output logic [15:0]            stall_cnt
);

  localparam int unsigned DW = LANES * WIDTH;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           r_state;
  logic             r_main_valid;
  logic [DW-1:0]    r_main_data;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_skid_valid;
  logic [DW-1:0]    r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_s_ready;
  logic [1:0]       r_occ;
  logic [15:0]      r_stall_cnt;

  logic w_push;
  logic w_pop;
  logic w_stall;

  assign w_push  = s_valid && r_s_ready;
  assign w_pop   = r_main_valid && m_ready;
  assign w_stall = r_main_valid && !m_ready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= StEmpty;
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_tag   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
      r_s_ready    <= 1'b0;
      r_occ        <= 2'd0;
      r_stall_cnt  <= 16'd0;
    end else begin
      // Stall counting is independent of flush; it only saturates.
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (ld) begin
        r_state      <= StEmpty;
        r_main_valid <= 1'b0;
        r_main_data  <= '0;
        r_main_tag   <= '0;
        r_skid_valid <= 1'b0;
        r_skid_data  <= '0;
        r_skid_tag   <= '0;
        r_s_ready    <= 1'b1;
        r_occ        <= 2'd0;
      end else begin
        // s_ready mirrors "skid empty after this edge"; only a push into skid
        // or a stalled FULL state pulls it low.
        r_s_ready <= 1'b1;
        unique case (r_state)
          StEmpty: begin
            if (w_push) begin
              r_main_data  <= s_data;
              r_main_tag   <= s_tag;
              r_main_valid <= 1'b1;
              r_state      <= StOne;
              r_occ        <= 2'd1;
            end
          end
          StOne: begin
            if (w_push && w_pop) begin
              r_main_data <= s_data;
              r_main_tag  <= s_tag;
            end else if (w_push) begin
              r_skid_data  <= s_data;
              r_skid_tag   <= s_tag;
              r_skid_valid <= 1'b1;
              r_state      <= StFull;
              r_occ        <= 2'd2;
              r_s_ready    <= 1'b0;
            end else if (w_pop) begin
              // Payload is kept; only the valid bit drops.
              r_main_valid <= 1'b0;
              r_state      <= StEmpty;
              r_occ        <= 2'd0;
            end
          end
          StFull: begin
            r_s_ready <= w_pop;
            if (w_pop) begin
              r_main_data  <= r_skid_data;
              r_main_tag   <= r_skid_tag;
              r_skid_valid <= 1'b0;
              r_state      <= StOne;
              r_occ        <= 2'd1;
            end
          end
          default: begin
            r_state <= StEmpty;
          end
        endcase
      end
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_main_valid;
  assign m_data    = r_main_data;
  assign m_tag     = r_main_tag;
  assign occupancy = r_occ;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ff_div_skid.sv
// Self-checking bench for ff_div_skid. A default-size instance covers the
// directed scenarios; an 8-bit x 2-lane instance takes randomized traffic.
// The reference model is a bounded queue of held beats.
module tb_ff_div_skid;

  logic         aclk;
  logic         aresetn;
  logic         ld;

  logic         s_valid, s_ready, m_valid, m_ready;
  logic [127:0] s_data, m_data;
  logic [3:0]   s_tag, m_tag;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cnt;

  logic         sm_s_valid, sm_s_ready, sm_m_valid, sm_m_ready;
  logic [15:0]  sm_s_data, sm_m_data;
  logic [3:0]   sm_s_tag, sm_m_tag;
  logic [1:0]   sm_occupancy;
  logic [15:0]  sm_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of held beats {tag, data}, front is main.
  logic [131:0] q[$];
  bit           mdl_ready;
  logic [15:0]  mdl_stall;
  logic [131:0] mdl_last;

  ff_div_skid #(.WIDTH(32), .LANES(4), .TAG_W(4)) u_dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .ld        (ld),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_tag     (s_tag),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_tag     (m_tag),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  ff_div_skid #(.WIDTH(8), .LANES(2), .TAG_W(4)) u_dut_sm (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .ld        (ld),
    .s_valid   (sm_s_valid),
    .s_ready   (sm_s_ready),
    .s_data    (sm_s_data),
    .s_tag     (sm_s_tag),
    .m_valid   (sm_m_valid),
    .m_ready   (sm_m_ready),
    .m_data    (sm_m_data),
    .m_tag     (sm_m_tag),
    .occupancy (sm_occupancy),
    .stall_cnt (sm_stall_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic logic [151:0] exp_vec();
    return {q.size() != 0, mdl_ready, 2'(q.size()), mdl_last[131:128], mdl_last[127:0],
            mdl_stall};
  endfunction

  function automatic logic [151:0] act_vec(input bit sel);
    if (sel) return {sm_m_valid, sm_s_ready, sm_occupancy, sm_m_tag, 112'b0, sm_m_data,
                     sm_stall_cnt};
    return {m_valid, s_ready, occupancy, m_tag, m_data, stall_cnt};
  endfunction

  function automatic logic [127:0] lanes_for(input int tag);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h1000_0000 + 32'(tag * 4 + k);
    return d;
  endfunction

  task automatic mdl_reset();
    q.delete();
    mdl_ready = 1'b0;
    mdl_stall = 16'd0;
    mdl_last  = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then
  // clock the DUT and land on the following falling edge.
  task automatic tick(input bit sel);
    bit           sv, mr, push, pop;
    logic [131:0] beat;
    if (sel) begin
      sv = sm_s_valid; mr = sm_m_ready; beat = {sm_s_tag, 112'b0, sm_s_data};
    end else begin
      sv = s_valid; mr = m_ready; beat = {s_tag, s_data};
    end
    push = sv && mdl_ready;
    pop  = (q.size() != 0) && mr;
    if ((q.size() != 0) && !mr && (mdl_stall != 16'hFFFF)) mdl_stall = mdl_stall + 16'd1;
    if (ld) begin
      q.delete();
      mdl_last = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(beat);
      if (q.size() != 0) mdl_last = q[0];
    end
    mdl_ready = (q.size() < 2);
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    ld = 0; s_valid = 0; s_data = '0; s_tag = '0; m_ready = 0;
    sm_s_valid = 0; sm_s_data = '0; sm_s_tag = '0; sm_m_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    mdl_reset();
    #1;
    n_checks++;
    if (act_vec(0) !== 152'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", act_vec(0));
    end
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;
    #1;
    n_checks++;
    if (act_vec(0) !== exp_vec()) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", act_vec(0), exp_vec());
    end
    @(negedge aclk);
    tick(0);
    n_checks++;
    if (act_vec(0) !== exp_vec() || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_edge: got %h want %h", act_vec(0), exp_vec());
    end
  endtask

  task automatic test_stream();
    m_ready = 1;
    for (int t = 0; t < 8; t++) begin
      s_valid = 1; s_tag = 4'(t); s_data = lanes_for(t);
      tick(0);
      n_checks++;
      if (act_vec(0) !== exp_vec() || m_valid !== 1'b1 || m_tag !== 4'(t)
          || m_data !== lanes_for(t) || occupancy > 2'd1 || stall_cnt !== 16'd0) begin
        n_fail++; $display("FAIL stream_beat%0d: got %h want %h", t, act_vec(0), exp_vec());
      end
    end
    s_valid = 0;
    for (int i = 0; i < 2; i++) begin
      tick(0);
      n_checks++;
      if (act_vec(0) !== exp_vec()) begin
        n_fail++; $display("FAIL stream_drain: got %h want %h", act_vec(0), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    int obs[$];
    m_ready = 0;
    for (int t = 1; t <= 3; t++) begin
      s_valid = 1; s_tag = 4'(t); s_data = lanes_for(t);
      tick(0);
      n_checks++;
      if (act_vec(0) !== exp_vec()) begin
        n_fail++; $display("FAIL bp_push%0d: got %h want %h", t, act_vec(0), exp_vec());
      end
    end
    n_checks++;
    if (s_ready !== 1'b0 || occupancy !== 2'd2 || m_tag !== 4'd1) begin
      n_fail++; $display("FAIL bp_full: got rdy=%b occ=%0d tag=%0d want rdy=0 occ=2 tag=1",
                         s_ready, occupancy, m_tag);
    end
    m_ready = 1;
    for (int i = 0; i < 10; i++) begin
      if (m_valid) obs.push_back(int'(m_tag));
      if (s_valid && s_ready) begin
        tick(0);
        s_valid = 0;
      end else begin
        tick(0);
      end
      n_checks++;
      if (act_vec(0) !== exp_vec()) begin
        n_fail++; $display("FAIL bp_drain: got %h want %h", act_vec(0), exp_vec());
      end
    end
    n_checks++;
    if (obs.size() != 3 || obs[0] != 1 || obs[1] != 2 || obs[2] != 3) begin
      n_fail++; $display("FAIL bp_order: got %p want 1 2 3", obs);
    end
  endtask

  task automatic test_flush();
    logic [15:0] stall_before;
    m_ready = 0;
    for (int t = 6; t <= 7; t++) begin
      s_valid = 1; s_tag = 4'(t); s_data = lanes_for(t);
      tick(0);
    end
    n_checks++;
    if (occupancy !== 2'd2 || act_vec(0) !== exp_vec()) begin
      n_fail++; $display("FAIL flush_setup: got %h want %h", act_vec(0), exp_vec());
    end
    stall_before = mdl_stall;
    ld = 1; s_valid = 1; s_tag = 4'd5; s_data = lanes_for(5); m_ready = 1;
    tick(0);
    ld = 0; s_valid = 0;
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 128'd0 || m_tag !== 4'd0 || occupancy !== 2'd0
        || s_ready !== 1'b1 || stall_cnt !== stall_before) begin
      n_fail++; $display("FAIL flush_state: got %h want v=0 d=0 occ=0 rdy=1 stall=%h",
                         act_vec(0), stall_before);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0);
      n_checks++;
      if (m_valid !== 1'b0 || act_vec(0) !== exp_vec()) begin
        n_fail++; $display("FAIL flush_no_tag5: got %h want %h", act_vec(0), exp_vec());
      end
    end
  endtask

  task automatic test_stall_sat();
    s_valid = 1; s_tag = 4'd9; s_data = lanes_for(9); m_ready = 0;
    tick(0);
    s_valid = 0;
    for (int i = 0; i < 70000; i++) begin
      tick(0);
      if (i % 5000 == 0) begin
        n_checks++;
        if (act_vec(0) !== exp_vec()) begin
          n_fail++; $display("FAIL stall_run%0d: got %h want %h", i, act_vec(0), exp_vec());
        end
      end
    end
    n_checks++;
    if (stall_cnt !== 16'hFFFF || m_valid !== 1'b1 || m_tag !== 4'd9) begin
      n_fail++; $display("FAIL stall_saturate: got %h want FFFF", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    s_valid = 1; s_tag = 4'd10; s_data = lanes_for(10); m_ready = 0;
    tick(0);
    n_checks++;
    if (occupancy !== 2'd2 || act_vec(0) !== exp_vec()) begin
      n_fail++; $display("FAIL areset_setup: got %h want %h", act_vec(0), exp_vec());
    end
    #2 aresetn = 1'b0;
    #1;
    mdl_reset();
    n_checks++;
    if (act_vec(0) !== 152'd0) begin
      n_fail++; $display("FAIL areset_immediate: got %h want 0", act_vec(0));
    end
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0 || act_vec(0) !== exp_vec()) begin
      n_fail++; $display("FAIL areset_release: got %h want %h", act_vec(0), exp_vec());
    end
    @(negedge aclk);
    s_valid = 0;
    tick(0);
    n_checks++;
    if (s_ready !== 1'b1 || act_vec(0) !== exp_vec()) begin
      n_fail++; $display("FAIL areset_first_edge: got %h want %h", act_vec(0), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [19:0] sb[$];
    int          acc = 0;
    int          pops = 0;
    logic [19:0] exp_beat;
    idle_inputs();
    aresetn = 1'b0;
    mdl_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    tick(1);
    for (int i = 0; i < 2000; i++) begin
      sm_s_valid = 1'($urandom_range(1));
      sm_m_ready = 1'($urandom_range(1));
      sm_s_data  = 16'($urandom);
      sm_s_tag   = 4'($urandom);
      if (sm_m_valid && sm_m_ready) begin
        pops++;
        n_checks++;
        exp_beat = (sb.size() != 0) ? sb.pop_front() : 20'hxxxxx;
        if ({sm_m_tag, sm_m_data} !== exp_beat) begin
          n_fail++; $display("FAIL rand_order%0d: got %h want %h", i, {sm_m_tag, sm_m_data},
                             exp_beat);
        end
      end
      if (sm_s_valid && sm_s_ready) begin
        acc++;
        sb.push_back({sm_s_tag, sm_s_data});
      end
      tick(1);
      n_checks++;
      if (int'(sm_occupancy) != acc - pops || act_vec(1) !== exp_vec()) begin
        n_fail++; $display("FAIL rand_state%0d: got %h occ=%0d want %h occ=%0d", i, act_vec(1),
                           sm_occupancy, exp_vec(), acc - pops);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
